crtc_bus_arbiter: RTL and testbench

Bus arbiter between the Z80 CPU and the CRTC row-buffer DMA engine. It turns the CRTC busreq into a Z80 BUSRQ/BUSAK handshake and returns busack to the CRTC. It drives the shared main-RAM address, write-enable and write-data, giving them to whichever master owns the bus. It also implements the DMAC channel-2 enable bit and a status byte readable by the CPU.

---
 rtl/crtc_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_crtc_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crtc_bus_arbiter : Z80 / CRTC-DMA main-RAM arbiter with BUSRQ/BUSAK handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module crtc_bus_arbiter #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 1023,
  parameter logic [16:0] VRAM_BASE   = 17'h0F000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        crtc_busreq,
  output logic        crtc_busack,
  input  logic [11:0] crtc_adr,
  output logic [7:0]  crtc_data,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [16:0] cpu_adr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [16:0] ram_adr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  input  logic        dmac_we,
  input  logic        dmac_rd,
  input  logic [7:0]  dmac_din,
  output logic [7:0]  dmac_dout
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_GRANT = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] busak_sync;
  logic                   busak_s;
  logic                   owner_crtc;
  logic                   dma_en;
  logic                   timeout_flag;
  logic                   timeout_set;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   unused_din;

  assign unused_din = ^{dmac_din[7:3], dmac_din[1:0]};

  // BUSAK comes straight from the Z80 and is not related to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busak_sync <= '1;
    end else begin
      busak_sync <= {busak_sync[SYNC_STAGES-2:0], cpu_busak_n};
    end
  end

  assign busak_s = busak_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_en <= 1'b0;
    end else if (dmac_we) begin
      dma_en <= dmac_din[2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cpu_busrq_n <= 1'b1;
      crtc_busack <= 1'b0;
      owner_crtc  <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (crtc_busreq && dma_en) begin
            state       <= S_REQ;
            cpu_busrq_n <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        S_REQ: begin
          if (!busak_s) begin
            state       <= S_GRANT;
            crtc_busack <= 1'b1;
            owner_crtc  <= 1'b1;
          end else if (!crtc_busreq) begin
            state       <= S_REL;
            cpu_busrq_n <= 1'b1;
          end else if (wait_cnt != TIMEOUT_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GRANT: begin
          if (!crtc_busreq) begin
            state       <= S_REL;
            cpu_busrq_n <= 1'b1;
            crtc_busack <= 1'b0;
            owner_crtc  <= 1'b0;
          end
        end
        S_REL: begin
          // Hold off any new request until the Z80 has visibly let go.
          if (busak_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign timeout_set = (state == S_REQ) && (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_flag <= 1'b0;
      dmac_dout    <= 8'h00;
    end else begin
      if (timeout_set) begin
        timeout_flag <= 1'b1;
      end else if (dmac_rd) begin
        timeout_flag <= 1'b0;
      end
      dmac_dout <= {5'b0, dma_en, timeout_flag, owner_crtc};
    end
  end

  // CPU writes during a CRTC grant are dropped; the Z80 is halted then anyway.
  assign ram_adr   = owner_crtc ? (VRAM_BASE | {5'b0, crtc_adr}) : cpu_adr;
  assign ram_we    = owner_crtc ? 1'b0 : cpu_we;
  assign ram_wdata = cpu_wdata;
  assign crtc_data = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_crtc_bus_arbiter.sv
`default_nettype none
// tb_crtc_bus_arbiter : randomized self-checking bench for crtc_bus_arbiter
// Rev 1.0
module tb_crtc_bus_arbiter;

  localparam int          SYNC_STAGES = 2;
  localparam int          TIMEOUT     = 1023;
  localparam logic [16:0] VRAM_BASE   = 17'h0F000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        crtc_busreq;
  logic        crtc_busack;
  logic [11:0] crtc_adr;
  logic [7:0]  crtc_data;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [16:0] cpu_adr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [16:0] ram_adr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        dmac_we;
  logic        dmac_rd;
  logic [7:0]  dmac_din;
  logic [7:0]  dmac_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic crtc_owns = 1'b0;

  always #5 clk = ~clk;

  crtc_bus_arbiter #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT),
    .VRAM_BASE  (VRAM_BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .crtc_busreq(crtc_busreq),
    .crtc_busack(crtc_busack),
    .crtc_adr   (crtc_adr),
    .crtc_data  (crtc_data),
    .cpu_busrq_n(cpu_busrq_n),
    .cpu_busak_n(cpu_busak_n),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .ram_adr    (ram_adr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .dmac_we    (dmac_we),
    .dmac_rd    (dmac_rd),
    .dmac_din   (dmac_din),
    .dmac_dout  (dmac_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference mux: the CRTC window is VRAM_BASE plus the 12-bit offset.
  task automatic check_mux(input string tag);
    logic [16:0] exp_adr;
    cpu_adr   = 17'($urandom);
    crtc_adr  = 12'($urandom);
    cpu_wdata = 8'($urandom);
    ram_dout  = 8'($urandom);
    cpu_we    = crtc_owns ? 1'b1 : 1'($urandom);
    #1;
    exp_adr = crtc_owns ? (VRAM_BASE + 17'(crtc_adr)) : cpu_adr;
    chk({tag, "_adr"},   32'(ram_adr),   32'(exp_adr));
    chk({tag, "_we"},    32'(ram_we),    32'(crtc_owns ? 1'b0 : cpu_we));
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'(cpu_wdata));
    chk({tag, "_cdata"}, 32'(crtc_data), 32'(ram_dout));
    cpu_we = 1'b0;
  endtask

  task automatic set_dma_en(input logic en);
    dmac_din = (8'($urandom) & 8'hFB) | (en ? 8'h04 : 8'h00);
    dmac_we  = 1'b1;
    step();
    dmac_we  = 1'b0;
    step();
    chk("dma_en_bit", 32'(dmac_dout[2]), 32'(en));
  endtask

  task automatic wait_busack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!crtc_busack && n < 12);
  endtask

  task automatic wait_busrq_low(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (cpu_busrq_n && n < 12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    logic disable_en;

    reset_n     = 1'b0;
    crtc_busreq = 1'b1;
    cpu_busak_n = 1'b1;
    crtc_adr    = '0;
    cpu_adr     = '0;
    cpu_wdata   = '0;
    cpu_we      = 1'b0;
    ram_dout    = '0;
    dmac_we     = 1'b0;
    dmac_rd     = 1'b0;
    dmac_din    = '0;
    repeat (3) step();
    chk("rst_busrq", 32'(cpu_busrq_n), 32'd1);
    chk("rst_busack", 32'(crtc_busack), 32'd0);
    chk("rst_dout", 32'(dmac_dout), 32'h00);
    reset_n = 1'b1;

    // Request pending but DMA disabled: the bus must never be requested.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("noen_busrq", 32'(cpu_busrq_n), 32'd1);
      chk("noen_busack", 32'(crtc_busack), 32'd0);
    end
    chk("noen_dout", 32'(dmac_dout), 32'h00);
    check_mux("idle_mux");

    // Grant / release rounds with random Z80 response times.
    for (int iter = 0; iter < 4; iter++) begin
      disable_en  = (iter == 1);
      crtc_busreq = 1'b0;
      step();
      set_dma_en(1'b1);
      crtc_busreq = 1'b1;
      step();
      chk("req_busrq", 32'(cpu_busrq_n), 32'd0);
      d = $urandom_range(1, 5);
      for (int i = 0; i < d; i++) begin
        step();
        chk("req_busack", 32'(crtc_busack), 32'd0);
        check_mux("req_mux");
      end
      cpu_busak_n = 1'b0;
      wait_busack(n);
      chk("grant_latency", 32'(n), 32'(SYNC_STAGES + 1));
      crtc_owns = 1'b1;
      for (int i = 0; i < 3; i++) check_mux("grant_mux");
      step();
      chk("grant_owner", 32'(dmac_dout[0]), 32'd1);
      if (disable_en) begin
        dmac_din = 8'h00;
        dmac_we  = 1'b1;
        step();
        dmac_we  = 1'b0;
        step();
        chk("dis_keep_busack", 32'(crtc_busack), 32'd1);
      end
      crtc_busreq = 1'b0;
      step();
      crtc_owns = 1'b0;
      chk("rel_busack", 32'(crtc_busack), 32'd0);
      chk("rel_busrq", 32'(cpu_busrq_n), 32'd1);
      check_mux("rel_mux");
      crtc_busreq = 1'b1;
      d = $urandom_range(1, 4);
      for (int i = 0; i < d; i++) begin
        step();
        chk("rel_hold_busrq", 32'(cpu_busrq_n), 32'd1);
      end
      cpu_busak_n = 1'b1;
      if (disable_en) begin
        for (int i = 0; i < 20; i++) begin
          step();
          chk("dis_busrq", 32'(cpu_busrq_n), 32'd1);
        end
        chk("dis_dout", 32'(dmac_dout), 32'h00);
      end else begin
        wait_busrq_low(n);
        chk("rereq_latency", 32'(n), 32'(SYNC_STAGES + 2));
        // Abandon the request before BUSAK: no grant must follow.
        crtc_busreq = 1'b0;
        step();
        chk("abort_busrq", 32'(cpu_busrq_n), 32'd1);
        for (int i = 0; i < 6; i++) begin
          step();
          chk("abort_busack", 32'(crtc_busack), 32'd0);
        end
      end
      crtc_busreq = 1'b0;
      repeat (5) step();
    end

    // Timeout: Z80 never answers for well over TIMEOUT cycles.
    set_dma_en(1'b1);
    crtc_busreq = 1'b1;
    step();
    chk("to_busrq", 32'(cpu_busrq_n), 32'd0);
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (i == TIMEOUT - 5) chk("to_early", 32'(dmac_dout[1]), 32'd0);
      if (i == TIMEOUT + 5) chk("to_set", 32'(dmac_dout[1]), 32'd1);
      if (i == TIMEOUT + 20) dmac_rd = 1'b1;
      if (i == TIMEOUT + 21) dmac_rd = 1'b0;
      if (i == TIMEOUT + 24) chk("to_set_wins", 32'(dmac_dout[1]), 32'd1);
    end
    chk("to_still", 32'(dmac_dout[1]), 32'd1);
    chk("to_no_busack", 32'(crtc_busack), 32'd0);
    cpu_busak_n = 1'b0;
    wait_busack(n);
    chk("to_grant_latency", 32'(n), 32'(SYNC_STAGES + 1));
    crtc_owns = 1'b1;
    dmac_rd = 1'b1;
    step();
    dmac_rd = 1'b0;
    step();
    chk("to_cleared", 32'(dmac_dout[1]), 32'd0);
    chk("to_owner", 32'(dmac_dout[0]), 32'd1);
    check_mux("to_grant_mux");

    // Asynchronous reset in the middle of a grant.
    reset_n   = 1'b0;
    crtc_owns = 1'b0;
    #1;
    chk("arst_busrq", 32'(cpu_busrq_n), 32'd1);
    chk("arst_busack", 32'(crtc_busack), 32'd0);
    chk("arst_dout", 32'(dmac_dout), 32'h00);
    check_mux("arst_mux");
    step();
    cpu_busak_n = 1'b1;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("arst_noreq", 32'(cpu_busrq_n), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
